regfl_wr_arb: RTL and testbench
===============================

Name: regfl_wr_arb

Overview:
- Write-port controller for the 8 x 64-bit register file: owns its single write port (we, s, d) and shares it among N requesters.
- After reset or on command, first runs a clear sweep that writes 0 to all 8 entries, since the register file has no clear path of its own.
- Then arbitrates requesters round-robin, one write per cycle, with registered write-port outputs.

Parameters:
N, 4, number of write requesters (2..8)
W, 64, data width, matches register file entry width
A, 3, index width; register file depth is 2**A = 8

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
req  input  N  req[i]: requester i has a write pending
req_idx  input  N*A  slice [i*A +: A] = target index of requester i
req_data  input  N*W  slice [i*W +: W] = write data of requester i
gnt  output  N  one-hot grant, combinational; transfer occurs at an edge where req[i] & gnt[i]
stall  input  1  when 1, no grants issued in RUN
clr_all  input  1  request a new clear sweep
init_done  output  1  1 when the sweep is complete and arbitration is enabled
we  output  1  registered write enable to register file
s  output  A  registered write index
d  output  W  registered write data

Behaviour:
- Async reset (rst=1): state=INIT, sweep counter cnt=0, rr pointer ptr=0, we=0, s=0, d=0, init_done=0. gnt=0 whenever state!=RUN.
- Reset asserted mid-write drops we immediately; no partial write is issued.
- States: INIT (clear sweep) and RUN (arbitration).

INIT:
- Each edge: we<=1, s<=cnt, d<=0, cnt<=cnt+1.
- On the edge that registers s=2**A-1: state<=RUN, init_done<=1, cnt<=0.
- stall is ignored in INIT.
- clr_all=1 in INIT restarts the sweep: cnt<=0, and the next registered write is s=0.
- After reset release, we is high for exactly 8 consecutive cycles with s=0,1,...,7 and d=0.

RUN:
- Grant rule: gnt[i]=1 for the first i with req[i]=1, scanning i=ptr, ptr+1, ..., N-1, 0, ..., ptr-1. At most one bit is set.
- gnt=0 if stall=1, clr_all=1, or req=0.
- Edge with a grant to i: we<=1, s<=req_idx slice i, d<=req_data slice i, ptr<=(i+1) mod N.
- Edge without a grant: we<=0; s, d and ptr hold.
- Latency: a transfer at edge k produces we=1 in the cycle after edge k, so the register file captures the data at edge k+1.
- Throughput: one write per cycle; back-to-back grants allowed, including repeated grants to the same requester when it is the only one requesting.
- A requester keeps req, idx and data stable until it sees the transfer edge. It may present its next write immediately afterwards.
- clr_all=1 in RUN: no grant that cycle. At the edge: state<=INIT, cnt<=0, init_done<=0, ptr holds, we<=0.
- Pending requests are not lost: they wait, with gnt=0, until the sweep ends.
- Same-index collisions are not detected. Writes land in grant order, so the last granted writer wins.
- ptr wraps from N-1 to 0. With N not a power of two, ptr never takes values >= N.

Test Plan:
- Reset sweep: assert rst, release, keep req=0 -> we=1 for 8 cycles with s=0..7, d=0; init_done rises with the last sweep write; every regfl entry reads 0.
- Single requester streaming: req=4'b0001, data changing every transfer -> gnt[0]=1 every cycle; we stays high continuously; s and d follow the inputs one cycle late.
- Round-robin fairness: req=4'b1111 held for 8 cycles with ptr=0 -> grant order 0,1,2,3,0,1,2,3; then req=4'b1010 -> grants alternate 1,3 starting from ptr.
- Stall: req=4'b0100 with stall=1 for 3 cycles -> gnt=0 and we=0 for those cycles, ptr unchanged; on stall=0 the grant goes to requester 2 and the write appears the next cycle.
- clr_all mid-traffic: while req=4'b0011 is active, pulse clr_all -> no grant that cycle, init_done=0, 8-write zero sweep; afterwards grants resume from the held ptr and only the post-sweep writes persist.
- Async reset mid-operation: assert rst between edges during a RUN write -> we, s, d and init_done drop to 0 immediately; a full sweep follows release.

Source files
------------

// File: rtl/regfl_wr_arb.sv
// Write-port controller for the 8-entry register file: zero-fills every entry after
// reset or on clr_all, then shares the single write port among N requesters round-robin.
module regfl_wr_arb #(
  parameter int N = 4,
  parameter int W = 64,
  parameter int A = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*A-1:0]   req_idx,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     gnt,
  input  logic             stall,
  input  logic             clr_all,
  output logic             init_done,
  output logic             we,
  output logic [A-1:0]     s,
  output logic [W-1:0]     d
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [A-1:0] LAST_IDX = {A{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [A-1:0]   cnt_r, cnt_s;
  logic [PW-1:0]  ptr_r, ptr_s;
  logic           we_s;
  logic [A-1:0]   s_s;
  logic [W-1:0]   d_s;
  logic           done_s;
  logic           gnt_vld_s;
  logic [PW-1:0]  gnt_idx_s;

  // Requester index reached by stepping off positions past base, wrapping at N.
  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) begin
      sum = sum - N;
    end else begin
      sum = sum;
    end
    return PW'(sum);
  endfunction

  // Round-robin search starting at ptr_r; first hit wins.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    if (state_r == ST_RUN && !stall && !clr_all) begin
      for (int k = 0; k < N; k++) begin
        if (!gnt_vld_s && req[rot_idx(ptr_r, k)]) begin
          gnt_vld_s = 1'b1;
          gnt_idx_s = rot_idx(ptr_r, k);
        end else begin
          gnt_vld_s = gnt_vld_s;
        end
      end
    end else begin
      gnt_vld_s = 1'b0;
    end
  end

  // One-hot grant decode.
  always_comb begin
    if (gnt_vld_s) begin
      gnt = N'(1) << gnt_idx_s;
    end else begin
      gnt = '0;
    end
  end

  // Next-state and next write-port values.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    we_s    = 1'b0;
    s_s     = s;
    d_s     = d;
    done_s  = init_done;
    case (state_r)
      ST_INIT: begin
        if (clr_all) begin
          cnt_s = '0;
          we_s  = 1'b0;
        end else begin
          we_s = 1'b1;
          s_s  = cnt_r;
          d_s  = '0;
          if (cnt_r == LAST_IDX) begin
            state_s = ST_RUN;
            done_s  = 1'b1;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + A'(1);
          end
        end
      end
      ST_RUN: begin
        if (clr_all) begin
          state_s = ST_INIT;
          cnt_s   = '0;
          done_s  = 1'b0;
          we_s    = 1'b0;
        end else if (gnt_vld_s) begin
          we_s  = 1'b1;
          s_s   = req_idx[int'(gnt_idx_s)*A +: A];
          d_s   = req_data[int'(gnt_idx_s)*W +: W];
          ptr_s = (gnt_idx_s == PW'(N-1)) ? '0 : gnt_idx_s + PW'(1);
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = '0;
        done_s  = 1'b0;
        we_s    = 1'b0;
      end
    endcase
  end

  // State and registered write port; reset kills any in-flight write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_INIT;
      cnt_r     <= '0;
      ptr_r     <= '0;
      we        <= 1'b0;
      s         <= '0;
      d         <= '0;
      init_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      ptr_r     <= ptr_s;
      we        <= we_s;
      s         <= s_s;
      d         <= d_s;
      init_done <= done_s;
    end
  end

endmodule

// File: tb/tb_regfl_wr_arb.sv
// Self-checking bench for regfl_wr_arb: directed sequences, a vector table and
// randomized traffic checked against a behavioural model of the write port and register file.
module tb_regfl_wr_arb;

  localparam int N = 4;
  localparam int W = 64;
  localparam int A = 3;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*A-1:0] req_idx;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           stall;
  logic           clr_all;
  logic           init_done;
  logic           we;
  logic [A-1:0]   s;
  logic [W-1:0]   d;

  always #5 clk = ~clk;

  regfl_wr_arb #(.N(N), .W(W), .A(A)) dut (
    .clk(clk), .rst(rst), .req(req), .req_idx(req_idx), .req_data(req_data),
    .gnt(gnt), .stall(stall), .clr_all(clr_all), .init_done(init_done),
    .we(we), .s(s), .d(d)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: sweeping flag + position, rotating pointer, expected port and file.
  bit           m_init;
  int           m_pos;
  int           m_ptr;
  bit           m_we;
  bit           m_done;
  logic [A-1:0] m_s;
  logic [W-1:0] m_d;
  logic [W-1:0] m_rf [D];
  logic [W-1:0] dut_rf [D];
  int           m_pick;
  logic [N-1:0] last_gnt;
  logic [N-1:0] g_seen;

  // Register file as seen from the DUT's write port.
  always @(posedge clk) begin
    if (we === 1'b1) dut_rf[s] <= d;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick();
    if (m_init || stall || clr_all) return -1;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_init = 1'b1; m_pos = 0; m_ptr = 0; m_we = 1'b0;
    m_s = '0; m_d = '0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    if (m_init) begin
      if (clr_all) begin
        m_pos = 0;
        m_we  = 1'b0;
      end else begin
        m_we = 1'b1;
        m_s  = A'(m_pos);
        m_d  = '0;
        m_rf[m_pos] = '0;
        if (m_pos == D - 1) begin
          m_init = 1'b0; m_done = 1'b1; m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end else if (clr_all) begin
      m_init = 1'b1; m_pos = 0; m_done = 1'b0; m_we = 1'b0;
    end else if (m_pick >= 0) begin
      m_we  = 1'b1;
      m_s   = req_idx[m_pick*A +: A];
      m_d   = req_data[m_pick*W +: W];
      m_ptr = (m_pick + 1) % N;
      m_rf[m_s] = m_d;
    end else begin
      m_we = 1'b0;
    end
  endtask

  // One clock: grant checked before the edge, registered port checked just after.
  task automatic do_cycle();
    @(negedge clk);
    m_pick   = model_pick();
    last_gnt = (m_pick >= 0) ? (N'(1) << m_pick) : '0;
    g_seen   = gnt;
    chk("gnt", 64'(gnt), 64'(last_gnt));
    @(posedge clk);
    model_edge();
    #1;
    chk("we", 64'(we), 64'(m_we));
    chk("s", 64'(s), 64'(m_s));
    chk("d", d, m_d);
    chk("init_done", 64'(init_done), 64'(m_done));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_s", 64'(s), 64'(0));
    chk("rst_d", d, 64'(0));
    chk("rst_done", 64'(init_done), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic sweep_check();
    for (int k = 0; k < D; k++) begin
      do_cycle();
      chk("sweep_gnt", 64'(g_seen), 64'(0));
      chk("sweep_we", 64'(we), 64'(1));
      chk("sweep_s", 64'(s), 64'(k));
      chk("sweep_d", d, 64'(0));
      chk("sweep_done", 64'(init_done), 64'(k == D - 1));
    end
  endtask

  task automatic set_req(input int i, input logic [A-1:0] idx, input logic [W-1:0] dat);
    req_idx[i*A +: A]  = idx;
    req_data[i*W +: W] = dat;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         stall;
    logic [N-1:0] gnt;
    logic         we;
    logic [A-1:0] s;
  } vec_t;

  vec_t tbl [17];
  bit   pend [N];

  logic [W-1:0] d0, d1;

  initial begin
    // requester i targets index 7-i
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 3'd7};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 3'd6};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 3'd5};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3'd4};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 3'd7};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 3'd6};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 3'd5};
    tbl[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3'd4};
    tbl[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 3'd6};
    tbl[9]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 3'd4};
    tbl[10] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 3'd6};
    tbl[11] = '{4'b1010, 1'b0, 4'b1000, 1'b1, 3'd4};
    tbl[12] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 3'd4};
    tbl[13] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 3'd4};
    tbl[14] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 3'd4};
    tbl[15] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 3'd5};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 3'd5};

    rst = 1'b0; req = '0; stall = 1'b0; clr_all = 1'b0;
    req_idx = '0; req_data = '0;
    #2;
    do_reset();

    // reset sweep, then an idle cycle and a zero-filled file
    sweep_check();
    do_cycle();
    chk("post_sweep_we", 64'(we), 64'(0));
    for (int k = 0; k < D; k++) chk("rf_zero", dut_rf[k], 64'(0));

    // vector table: round robin from ptr 0, alternating pair, stall
    for (int i = 0; i < N; i++) set_req(i, A'(7 - i), 64'hA5A5_0000_0000_0000 | 64'(i));
    for (int v = 0; v < 17; v++) begin
      req   = tbl[v].req;
      stall = tbl[v].stall;
      do_cycle();
      chk("tbl_gnt", 64'(g_seen), 64'(tbl[v].gnt));
      chk("tbl_we", 64'(we), 64'(tbl[v].we));
      chk("tbl_s", 64'(s), 64'(tbl[v].s));
    end
    stall = 1'b0;

    // single requester streaming, new idx/data after every transfer
    req = 4'b0001;
    for (int t = 0; t < 6; t++) begin
      set_req(0, A'(t), 64'h1234_0000_0000_0000 + 64'(t));
      do_cycle();
      chk("stream_gnt", 64'(g_seen), 64'(1));
      chk("stream_we", 64'(we), 64'(1));
      chk("stream_s", 64'(s), 64'(t));
      chk("stream_d", d, 64'h1234_0000_0000_0000 + 64'(t));
    end

    // clr_all mid-traffic: pre-clear writes must not survive the sweep
    req = 4'b0011;
    set_req(0, 3'd2, 64'hDEAD_0000_0000_0000);
    set_req(1, 3'd5, 64'hDEAD_1111_0000_0000);
    do_cycle();
    do_cycle();
    d0 = 64'h0C0C_0000_0000_0002;
    d1 = 64'h1C1C_0000_0000_0005;
    set_req(0, 3'd2, d0);
    set_req(1, 3'd5, d1);
    clr_all = 1'b1;
    do_cycle();
    chk("clr_gnt", 64'(g_seen), 64'(0));
    chk("clr_we", 64'(we), 64'(0));
    chk("clr_done", 64'(init_done), 64'(0));
    clr_all = 1'b0;
    sweep_check();
    do_cycle();
    chk("resume_gnt", 64'(g_seen), 64'(4'b0010));
    do_cycle();
    chk("resume_gnt2", 64'(g_seen), 64'(4'b0001));
    req = '0;
    do_cycle();
    for (int k = 0; k < D; k++)
      chk("rf_after_clr", dut_rf[k], (k == 2) ? d0 : ((k == 5) ? d1 : 64'(0)));

    // async reset while a write is on the port
    req = 4'b0001;
    set_req(0, 3'd6, 64'hFEED_FACE_0000_0001);
    do_cycle();
    chk("inflight_we", 64'(we), 64'(1));
    req = '0;
    do_reset();
    sweep_check();

    // randomized traffic against the model
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, A'($urandom_range(0, D - 1)), {$urandom, $urandom});
        end
        req[i] = pend[i];
      end
      stall   = ($urandom_range(0, 7) == 0);
      clr_all = (!m_init && $urandom_range(0, 99) == 0);
      do_cycle();
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i]) pend[i] = 1'b0;
      end
    end
    req = '0; stall = 1'b0; clr_all = 1'b0;
    for (int c = 0; c < 12 && m_init; c++) do_cycle();
    do_cycle();
    for (int k = 0; k < D; k++) chk("rf_random", dut_rf[k], m_rf[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
